// File: rtl/floo_pkg.sv
// Shared NoC types: AXI channel enumeration and link arbiter state encoding.
package floo_pkg;

  typedef enum logic [2:0] {
    AxiAw = 3'd0,
    AxiW  = 3'd1,
    AxiAr = 3'd2,
    AxiB  = 3'd3,
    AxiR  = 3'd4
  } axi_ch_e;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbHold   = 2'd1,
    ArbWBurst = 2'd2
  } link_arb_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/floo_link_arbiter_if.sv
// Bundle of per-source flit handshakes and the shared outgoing link handshake.
interface floo_link_arbiter_if #(
  parameter int NumInp    = 3,
  parameter int FlitWidth = 64
);
  localparam int IdxW = $clog2(NumInp);

  logic [NumInp-1:0]                valid_i;
  logic [NumInp-1:0]                ready_o;
  logic [NumInp-1:0][FlitWidth-1:0] data_i;
  logic [NumInp-1:0]                last_i;
  logic                             valid_o;
  logic                             ready_i;
  logic [FlitWidth-1:0]             data_o;
  logic [IdxW-1:0]                  idx_o;

  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, idx_o
  );

  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, idx_o
  );
endinterface

// File: rtl/floo_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr, wrapping.
module floo_rr_pick #(
  parameter  int NumInp = 3,
  localparam int IdxW   = $clog2(NumInp)
) (
  input  logic [NumInp-1:0] req_i,
  input  logic [IdxW-1:0]   rr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  logic [IdxW-1:0] cand;

  // Scan farthest offset first so the nearest request overwrites the result.
  always_comb begin
    idx_o   = rr_i;
    found_o = 1'b0;
    cand    = '0;
    for (int off = NumInp - 1; off >= 0; off--) begin
      cand = IdxW'((int'(rr_i) + off) % NumInp);
      if (req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floo_link_arbiter.sv
// Wormhole-aware round-robin arbiter for one outgoing Floo link with AW->W coupling.
// Optional stall counter output enabled by FLOO_LINK_ARB_STALL_CNT_EN.
module floo_link_arbiter
  import floo_pkg::*;
#(
  parameter int NumInp    = 3,
  parameter int FlitWidth = 64,
  parameter bit EnAwW     = 1'b1,
  parameter int AwIdx     = int'(AxiAw),
  parameter int WIdx      = int'(AxiW)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  floo_link_arbiter_if.slave   link_io
`ifdef FLOO_LINK_ARB_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int IdxW = $clog2(NumInp);
  localparam logic [IdxW-1:0] AwSel = IdxW'(AwIdx);
  localparam logic [IdxW-1:0] WSel  = IdxW'(WIdx);

  link_arb_state_e      state_q, state_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [IdxW-1:0]      lock_q, lock_d;
  logic [IdxW-1:0]      grant, pick_idx;
  logic                 pick_found, grant_valid, xfer, gnt_last, gnt_is_aw;
  logic [FlitWidth-1:0] data_sel;

  floo_rr_pick #(.NumInp(NumInp)) i_rr_pick (
    .req_i   (link_io.valid_i),
    .rr_i    (rr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;

    case (state_q)
      ArbHold:   grant = lock_q;
      ArbWBurst: grant = WSel;
      default:   grant = pick_idx;
    endcase

    grant_valid = (state_q == ArbIdle) ? pick_found : link_io.valid_i[grant];
    data_sel    = link_io.data_i[grant];

    link_io.valid_o = grant_valid && !rst_i;
    link_io.data_o  = data_sel;
    link_io.idx_o   = grant;
    link_io.ready_o = '0;
    if (!rst_i) link_io.ready_o[grant] = link_io.ready_i;

    xfer      = link_io.valid_o && link_io.ready_i;
    gnt_last  = link_io.last_i[grant];
    gnt_is_aw = EnAwW && (grant == AwSel);

    if (xfer) begin
      case (state_q)
        ArbIdle: begin
          if (!gnt_last) begin
            state_d = ArbHold;
            lock_d  = grant;
          end else if (gnt_is_aw) begin
            state_d = ArbWBurst;
          end else begin
            rr_d = IdxW'(rr_next(int'(grant), NumInp));
          end
        end
        ArbHold: begin
          if (gnt_last) begin
            if (gnt_is_aw) begin
              state_d = ArbWBurst;
            end else begin
              state_d = ArbIdle;
              rr_d    = IdxW'(rr_next(int'(lock_q), NumInp));
            end
          end
        end
        ArbWBurst: begin
          if (gnt_last) begin
            state_d = ArbIdle;
            rr_d    = IdxW'(rr_next(AwIdx, NumInp));
          end
        end
        default: state_d = ArbIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ArbIdle;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end

`ifdef FLOO_LINK_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (link_io.valid_o && !link_io.ready_i && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_floo_link_arbiter.sv
// Directed bench: one instance with AW->W coupling, one without, sharing stimulus.
module tb_floo_link_arbiter;
  import floo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  floo_link_arbiter_if #(.NumInp(3), .FlitWidth(64)) bus0 ();
  floo_link_arbiter_if #(.NumInp(3), .FlitWidth(64)) bus1 ();

`ifdef FLOO_LINK_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt0, stall_cnt1;
`endif

  floo_link_arbiter #(.NumInp(3), .FlitWidth(64), .EnAwW(1'b1)) u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .link_io (bus0)
`ifdef FLOO_LINK_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt0)
`endif
  );

  floo_link_arbiter #(.NumInp(3), .FlitWidth(64), .EnAwW(1'b0)) u_dut_nc (
    .clk_i   (clk),
    .rst_i   (rst),
    .link_io (bus1)
`ifdef FLOO_LINK_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt1)
`endif
  );

  assign bus1.valid_i = bus0.valid_i;
  assign bus1.data_i  = bus0.data_i;
  assign bus1.last_i  = bus0.last_i;
  assign bus1.ready_i = bus0.ready_i;

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic r);
    bus0.valid_i = v;
    bus0.last_i  = l;
    bus0.ready_i = r;
    #1;
  endtask

  initial begin
    int exp_nc[4];
    int exp_cp[4];
    exp_nc = '{0, 1, 2, 0};
    exp_cp = '{0, 1, 1, 2};

    rst = 1'b1;
    bus0.data_i[0] = 64'hD000;
    bus0.data_i[1] = 64'hD001;
    bus0.data_i[2] = 64'hD002;
    drive(3'b111, 3'b111, 1'b1);
    #2;
    check("rst_valid", 64'(bus0.valid_o), 64'd0);
    check("rst_ready", 64'(bus0.ready_o), 64'd0);
    check("rst_idx",   64'(bus0.idx_o),   64'd0);
    check("rst_data",  bus0.data_o,       64'hD000);
    check("rst_valid_nc", 64'(bus1.valid_o), 64'd0);
`ifdef FLOO_LINK_ARB_STALL_CNT_EN
    check("rst_stall", 64'(stall_cnt0), 64'd0);
`endif

    // Rotation with single-flit packets
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) next_cycle();
      drive(3'b111, 3'b111, 1'b1);
      check("rot_idx_nc",   64'(bus1.idx_o),   64'(exp_nc[k]));
      check("rot_ready_nc", 64'(bus1.ready_o), 64'(3'b001 << exp_nc[k]));
      check("rot_valid_nc", 64'(bus1.valid_o), 64'd1);
      check("rot_idx_cp",   64'(bus0.idx_o),   64'(exp_cp[k]));
    end

    // Wormhole hold on input 2
    do_reset();
    drive(3'b100, 3'b000, 1'b1);
    check("hold1_idx", 64'(bus1.idx_o), 64'd2);
    check("hold1_valid", 64'(bus1.valid_o), 64'd1);
    next_cycle();
    drive(3'b110, 3'b000, 1'b1);
    check("hold2_idx", 64'(bus0.idx_o), 64'd2);
    check("hold2_ready", 64'(bus0.ready_o), 64'h4);
    next_cycle();
    drive(3'b010, 3'b000, 1'b1);
    check("hold_drop_idx", 64'(bus1.idx_o), 64'd2);
    check("hold_drop_valid", 64'(bus1.valid_o), 64'd0);
    next_cycle();
    drive(3'b110, 3'b000, 1'b1);
    check("hold3_data", bus1.data_o, 64'hD002);
    next_cycle();
    drive(3'b110, 3'b100, 1'b1);
    check("hold4_idx", 64'(bus1.idx_o), 64'd2);
    next_cycle();
    drive(3'b110, 3'b010, 1'b1);
    check("after_hold_idx_nc", 64'(bus1.idx_o), 64'd1);
    check("after_hold_idx_cp", 64'(bus0.idx_o), 64'd1);
    check("after_hold_data", bus0.data_o, 64'hD001);

    // AW -> W coupling on the coupled instance
    do_reset();
    drive(3'b101, 3'b111, 1'b1);
    check("aw_idx", 64'(bus0.idx_o), 64'd0);
    check("aw_ready", 64'(bus0.ready_o), 64'h1);
    next_cycle();
    drive(3'b101, 3'b111, 1'b1);
    check("wwait_idx", 64'(bus0.idx_o), 64'd1);
    check("wwait_valid", 64'(bus0.valid_o), 64'd0);
    check("wwait_ready", 64'(bus0.ready_o), 64'h2);
    next_cycle();
    drive(3'b111, 3'b101, 1'b1);
    check("w1_idx", 64'(bus0.idx_o), 64'd1);
    check("w1_valid", 64'(bus0.valid_o), 64'd1);
    next_cycle();
    drive(3'b111, 3'b101, 1'b1);
    check("w2_idx", 64'(bus0.idx_o), 64'd1);
    next_cycle();
    drive(3'b111, 3'b111, 1'b1);
    check("w3_idx", 64'(bus0.idx_o), 64'd1);
    next_cycle();
    drive(3'b101, 3'b111, 1'b1);
    check("ar_idx", 64'(bus0.idx_o), 64'd2);
    check("ar_valid", 64'(bus0.valid_o), 64'd1);

    // Backpressure mid-packet
    do_reset();
    drive(3'b100, 3'b000, 1'b1);
    check("bp_start_idx", 64'(bus0.idx_o), 64'd2);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      drive(3'b110, 3'b000, 1'b0);
      check("bp_idx",   64'(bus0.idx_o),   64'd2);
      check("bp_data",  bus0.data_o,       64'hD002);
      check("bp_ready", 64'(bus0.ready_o), 64'd0);
    end
    next_cycle();
    drive(3'b110, 3'b100, 1'b1);
    check("bp_end_idx", 64'(bus0.idx_o), 64'd2);
`ifdef FLOO_LINK_ARB_STALL_CNT_EN
    check("bp_stall_cnt",    64'(stall_cnt0), 64'd5);
    check("bp_stall_cnt_nc", 64'(stall_cnt1), 64'd5);
`endif
    next_cycle();
    drive(3'b110, 3'b010, 1'b1);
    check("bp_next_idx", 64'(bus0.idx_o), 64'd1);

    // Reset asserted mid-burst
    do_reset();
    drive(3'b001, 3'b001, 1'b1);
    check("rb_aw_idx", 64'(bus0.idx_o), 64'd0);
    next_cycle();
    drive(3'b011, 3'b000, 1'b1);
    check("rb_w_idx", 64'(bus0.idx_o), 64'd1);
    next_cycle();
    rst = 1'b1;
    #1;
    check("rb_rst_valid", 64'(bus0.valid_o), 64'd0);
    check("rb_rst_ready", 64'(bus0.ready_o), 64'd0);
    check("rb_rst_idx",   64'(bus0.idx_o),   64'd0);
    next_cycle();
    rst = 1'b0;
    drive(3'b011, 3'b011, 1'b1);
    check("rb_post_idx",   64'(bus0.idx_o),   64'd0);
    check("rb_post_valid", 64'(bus0.valid_o), 64'd1);
    check("rb_post_ready", 64'(bus0.ready_o), 64'h1);

    // Pointer wrap-around
    do_reset();
    drive(3'b100, 3'b100, 1'b1);
    check("wrap_first_idx", 64'(bus1.idx_o), 64'd2);
    next_cycle();
    drive(3'b001, 3'b001, 1'b1);
    check("wrap_idx_nc",   64'(bus1.idx_o),   64'd0);
    check("wrap_valid_nc", 64'(bus1.valid_o), 64'd1);
    check("wrap_idx_cp",   64'(bus0.idx_o),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/floo_link_arbiter.md
# floo_link_arbiter

Wormhole-aware round-robin arbiter that shares one outgoing Floo link (e.g. `FlooReq` carrying AW, W, AR) between several channel sources inside a network interface. A grant is held for the whole of a multi-flit packet. An AW grant is always followed by exclusive service of the W source until its last beat. The block sits between the per-channel packers and the link output register of the chimney.

## Interface
- `NumInp`, default 3: number of requesting sources, at least 2.
- `FlitWidth`, default 64: width of one flit payload.
- `EnAwW`, default 1: enables AW→W burst coupling.
- `AwIdx`, default 0 (`AxiAw`): input index of the AW source.
- `WIdx`, default 1 (`AxiW`): input index of the W source. Must differ from `AwIdx`.
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `valid_i`  in  NumInp: per-source flit valid.
- `ready_o`  out  NumInp: per-source flit ready.
- `data_i`  in  NumInp×FlitWidth: per-source flit.
- `last_i`  in  NumInp: flit is the last of its packet. Single-flit packets tie this to 1.
- `valid_o`  out  1: link valid.
- `ready_i`  in  1: link ready.
- `data_o`  out  FlitWidth: granted flit.
- `idx_o`  out  $clog2(NumInp): index of the granted source.

## Operation
- The handshake is valid/ready on every port. A transfer happens when `valid_o && ready_i`.
- Only the granted source sees `ready_o[g] = ready_i`. All other `ready_o` bits are 0.
- `valid_o = valid_i[g]`, `data_o = data_i[g]`, `idx_o = g`.
- The round-robin pointer `rr` ranges over 0..NumInp-1.
  - In IDLE, `g` is the first `i` with `valid_i[i]` set, searching from `rr` upward with wrap-around modulo NumInp.
  - If no input is valid, `g = rr` and `valid_o = 0`.
- State machine:
  - IDLE, on a transfer:
    - `last_i[g]=0` → HOLD, with the lock on `g`.
    - `last_i[g]=1` and `g==AwIdx` and `EnAwW` → WBURST.
    - Otherwise, stay in IDLE and set `rr = (g+1) mod NumInp`.
  - HOLD: `g` stays the locked index, even if `valid_i[g]` drops. On a transfer with `last_i[g]=1`:
    - Locked index is AW and `EnAwW` → WBURST.
    - Otherwise → IDLE, with `rr = locked+1` mod NumInp.
  - WBURST: `g = WIdx` unconditionally. On a transfer with `last_i[WIdx]=1` → IDLE, with `rr = AwIdx+1` mod NumInp.
- A non-granted source never loses its request. Its valid simply waits.
- If a source asserts valid in the same cycle the lock is released, it takes part in the next IDLE arbitration. It is not granted in the releasing cycle.

## Timing
- Zero-cycle combinational path from `valid_i`/`data_i`/`ready_i` to the outputs. No added latency.
- `rr` and the lock state update on the rising `clk_i` edge after a transfer.
- Back-to-back packets from different sources are possible with no bubble: the cycle after a release is already an IDLE arbitration.
- While `rst_i=1`:
  - State is IDLE and `rr=0`.
  - `valid_o=0` and `ready_o='0` are forced regardless of the inputs.
  - `data_o` and `idx_o` follow the IDLE computation with `rr=0`.
- Reset asserted mid-packet or mid-burst drops the lock immediately. There is no recovery of the partial packet.
- Throughput: one flit per cycle while `ready_i=1`.

## Configuration
- Macro: `FLOO_LINK_ARB_STALL_CNT_EN`.
- Defined:
  - Adds port `stall_cnt_o`, out, 32 bits.
  - The counter increments every cycle with `valid_o && !ready_i`.
  - It saturates at 2^32-1 and clears on reset.
- Undefined: the port and the counter are absent, and there is no other behavioural difference.

## Structure
- `floo_pkg` gains the `link_arb_state_e` typedef (`ArbIdle`, `ArbHold`, `ArbWBurst`, 2 bits).
- Defaults for `AwIdx`/`WIdx` come from the existing `axi_ch_e` values.
- Sub-module `floo_rr_pick`: purely combinational, takes `req`, `rr` and `NumInp`, returns index and found flag. Reused elsewhere in the chimney.

## Test plan
- Rotation, single-flit packets: all 3 valid with `last=1`, `ready_i=1`, reset with `rr=0` → grants 0,1,2,0 on consecutive cycles. `idx_o` matches and the other `ready_o` bits are 0.
- Wormhole hold: input 2 sends 4 flits (`last` on the 4th) while input 1 stays valid → `idx_o=2` for 4 transfers, then input 1 is granted on the next cycle.
- AW→W coupling with `EnAwW=1`:
  - Sequence: AW single flit, AR valid throughout, W valid from cycle 3 with 3 beats.
  - Required: after the AW transfer, `idx_o=1` and `valid_o=0` until W is valid, then 3 W beats, then AR is granted.
- Backpressure: `ready_i=0` for 5 cycles mid-packet → `data_o` is stable, there is no grant change, and `stall_cnt_o` increases by 5 (macro defined).
- Reset mid-burst: `rst_i` asserted during WBURST → `valid_o=0` and `ready_o=0` during reset. After release the state is IDLE, `rr=0`, and input 0 is granted first.
- Wrap-around: only input 2 valid, then only input 0 → `rr` goes 0→0 (after 2 the pointer wraps), and input 0 is granted immediately.
